exp_max_align: RTL and testbench

- Pipelined, parametrised max-exponent finder for the GEMM/FFT block-floating-point datapath.
- Takes NUM_IN unsigned biased exponents per transaction and produces:
  - the maximum exponent;
  - the index of the input holding the maximum;
  - one right-shift amount per input (max − exp_i) for mantissa alignment.
- Sits between operand unpack and mantissa alignment shifters.
- Valid/ready streaming; one transaction per cycle when not stalled.

---
 rtl/exp_pkg.sv | 25 ++
 rtl/exp_max_align_if.sv | 29 ++
 rtl/exp_cmp_node.sv | 24 ++
 rtl/exp_max_align.sv | 159 +++++++++++++++
 tb/tb_exp_max_align.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/exp_pkg.sv
// Shared definitions for the exp_max_align block-floating-point exponent finder.
// Default configuration, the compare-node pair type and the tree tie-break rule.
package exp_pkg;

  localparam int DEF_EXP_WIDTH = 4;
  localparam int DEF_NUM_IN    = 4;
  localparam int DEF_SAT_SHIFT = 7;
  localparam int IDX_W         = $clog2(DEF_NUM_IN);
  localparam int LEVELS        = $clog2(DEF_NUM_IN);

  // Equal exponents resolve to the even (lower-index) node, so the reported
  // index is always the first lane holding the maximum.
  localparam bit TIE_LOWER_IDX = 1'b1;

  typedef struct packed {
    logic [DEF_EXP_WIDTH-1:0] exp;
    logic [IDX_W-1:0]         idx;
  } exp_node_t;

  // Registered tree nodes are stored level after level; level 1 starts at 0.
  function automatic int lvl_offset(input int num_in, input int lvl);
    return num_in - 2 * (num_in >> lvl);
  endfunction

endpackage

// File: rtl/exp_max_align_if.sv
// Streaming valid/ready bundle for exp_max_align: exponent input and aligned result output.
interface exp_max_align_if #(
  parameter int EXP_WIDTH = 4,
  parameter int NUM_IN    = 4
);

  localparam int IDX_W = $clog2(NUM_IN);

  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_IN*EXP_WIDTH-1:0] in_exp;
  logic                        out_valid;
  logic                        out_ready;
  logic [EXP_WIDTH-1:0]        out_max_exp;
  logic [IDX_W-1:0]            out_max_idx;
  logic [NUM_IN*EXP_WIDTH-1:0] out_shift;
  logic [NUM_IN-1:0]           out_sat;

  modport master (
    output in_valid, in_exp, out_ready,
    input  in_ready, out_valid, out_max_exp, out_max_idx, out_shift, out_sat
  );

  modport slave (
    input  in_valid, in_exp, out_ready,
    output in_ready, out_valid, out_max_exp, out_max_idx, out_shift, out_sat
  );

endinterface

// File: rtl/exp_cmp_node.sv
// Combinational two-input compare of (exp, idx) pairs for the max-exponent tree.
module exp_cmp_node
  import exp_pkg::*;
#(
  parameter int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter int IDX_BITS  = IDX_W
) (
  input  logic [EXP_WIDTH-1:0] a_exp,
  input  logic [IDX_BITS-1:0]  a_idx,
  input  logic [EXP_WIDTH-1:0] b_exp,
  input  logic [IDX_BITS-1:0]  b_idx,
  output logic [EXP_WIDTH-1:0] y_exp,
  output logic [IDX_BITS-1:0]  y_idx
);

  logic pick_b;

  always_comb begin
    pick_b = (b_exp > a_exp) || (!TIE_LOWER_IDX && (b_exp == a_exp));
    y_exp  = pick_b ? b_exp : a_exp;
    y_idx  = pick_b ? b_idx : a_idx;
  end

endmodule

// File: rtl/exp_max_align.sv
// Pipelined max-exponent finder with per-lane alignment shifts (latency LEVELS+1).
// Optional shift saturation is enabled by defining EXP_MAX_ALIGN_SAT_EN.
module exp_max_align #(
  parameter int EXP_WIDTH = 4,
  parameter int NUM_IN    = 4,
  parameter int SAT_SHIFT = 7
) (
  input logic               clk,
  input logic               rst_n,
  exp_max_align_if.slave    bus
);

  localparam int IDX_W  = $clog2(NUM_IN);
  localparam int LEVELS = $clog2(NUM_IN);
  localparam int NODES  = NUM_IN - 1;
  localparam int VEC_W  = NUM_IN * EXP_WIDTH;

  if (NUM_IN < 2 || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_num_in
    $error("NUM_IN must be a power of two and at least 2");
  end
  if (SAT_SHIFT >= (1 << EXP_WIDTH)) begin : g_bad_sat_shift
    $error("SAT_SHIFT must be below 2**EXP_WIDTH");
  end

  logic                                adv;
  logic [NODES-1:0][EXP_WIDTH-1:0]     win_exp;
  logic [NODES-1:0][IDX_W-1:0]         win_idx;
  logic [NODES-1:0][EXP_WIDTH-1:0]     node_exp_d, node_exp_q;
  logic [NODES-1:0][IDX_W-1:0]         node_idx_d, node_idx_q;
  logic [LEVELS-1:0]                   stg_valid_d, stg_valid_q;
  logic [LEVELS-1:0][VEC_W-1:0]        dly_d, dly_q;
  logic [NUM_IN-1:0][EXP_WIDTH-1:0]    raw_diff;
  logic [NUM_IN-1:0][EXP_WIDTH-1:0]    shift_calc;
  logic [NUM_IN-1:0]                   sat_calc;
  logic [EXP_WIDTH-1:0]                max_exp;

  logic                                out_valid_d, out_valid_q;
  logic [EXP_WIDTH-1:0]                out_max_exp_d, out_max_exp_q;
  logic [IDX_W-1:0]                    out_max_idx_d, out_max_idx_q;
  logic [VEC_W-1:0]                    out_shift_d, out_shift_q;
  logic [NUM_IN-1:0]                   out_sat_d, out_sat_q;

  // Level 1 compares raw input lanes; deeper levels compare the previous level's registers.
  for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_lvl
    for (genvar j = 0; j < (NUM_IN >> lv); j++) begin : g_node
      localparam int R = exp_pkg::lvl_offset(NUM_IN, lv) + j;
      logic [EXP_WIDTH-1:0] a_exp, b_exp;
      logic [IDX_W-1:0]     a_idx, b_idx;

      if (lv == 1) begin : g_leaf
        assign a_exp = bus.in_exp[EXP_WIDTH*(2*j)   +: EXP_WIDTH];
        assign b_exp = bus.in_exp[EXP_WIDTH*(2*j+1) +: EXP_WIDTH];
        assign a_idx = IDX_W'(2*j);
        assign b_idx = IDX_W'(2*j+1);
      end else begin : g_inner
        localparam int C = exp_pkg::lvl_offset(NUM_IN, lv - 1) + 2*j;
        assign a_exp = node_exp_q[C];
        assign b_exp = node_exp_q[C+1];
        assign a_idx = node_idx_q[C];
        assign b_idx = node_idx_q[C+1];
      end

      exp_cmp_node #(
        .EXP_WIDTH (EXP_WIDTH),
        .IDX_BITS  (IDX_W)
      ) u_cmp (
        .a_exp (a_exp),
        .a_idx (a_idx),
        .b_exp (b_exp),
        .b_idx (b_idx),
        .y_exp (win_exp[R]),
        .y_idx (win_idx[R])
      );
    end
  end

  always_comb begin
    adv         = !out_valid_q || bus.out_ready;
    node_exp_d  = node_exp_q;
    node_idx_d  = node_idx_q;
    stg_valid_d = stg_valid_q;
    dly_d       = dly_q;
    if (adv) begin
      node_exp_d     = win_exp;
      node_idx_d     = win_idx;
      stg_valid_d[0] = bus.in_valid;
      dly_d[0]       = bus.in_exp;
      for (int l = 1; l < LEVELS; l++) begin
        stg_valid_d[l] = stg_valid_q[l-1];
        dly_d[l]       = dly_q[l-1];
      end
    end
  end

  // Final stage: the delayed original exponents line up with the tree root.
  always_comb begin
    max_exp    = node_exp_q[NODES-1];
    raw_diff   = '0;
    shift_calc = '0;
    sat_calc   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      raw_diff[i] = max_exp - dly_q[LEVELS-1][EXP_WIDTH*i +: EXP_WIDTH];
`ifdef EXP_MAX_ALIGN_SAT_EN
      sat_calc[i]   = raw_diff[i] > EXP_WIDTH'(SAT_SHIFT);
      shift_calc[i] = sat_calc[i] ? EXP_WIDTH'(SAT_SHIFT) : raw_diff[i];
`else
      shift_calc[i] = raw_diff[i];
`endif
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_max_exp_d = out_max_exp_q;
    out_max_idx_d = out_max_idx_q;
    out_shift_d   = out_shift_q;
    out_sat_d     = out_sat_q;
    if (adv) begin
      out_valid_d   = stg_valid_q[LEVELS-1];
      out_max_exp_d = max_exp;
      out_max_idx_d = node_idx_q[NODES-1];
      out_shift_d   = shift_calc;
      out_sat_d     = sat_calc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_valid_q   <= '0;
      out_valid_q   <= 1'b0;
      out_max_exp_q <= '0;
      out_max_idx_q <= '0;
      out_shift_q   <= '0;
      out_sat_q     <= '0;
    end else begin
      stg_valid_q   <= stg_valid_d;
      out_valid_q   <= out_valid_d;
      out_max_exp_q <= out_max_exp_d;
      out_max_idx_q <= out_max_idx_d;
      out_shift_q   <= out_shift_d;
      out_sat_q     <= out_sat_d;
    end
  end

  // Payload registers are qualified by the stage valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    node_exp_q <= node_exp_d;
    node_idx_q <= node_idx_d;
    dly_q      <= dly_d;
  end

  assign bus.in_ready    = adv;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_max_exp = out_max_exp_q;
  assign bus.out_max_idx = out_max_idx_q;
  assign bus.out_shift   = out_shift_q;
  assign bus.out_sat     = out_sat_q;

endmodule

// File: tb/tb_exp_max_align.sv
// Self-checking bench for exp_max_align (NUM_IN=4, EXP_WIDTH=4, SAT_SHIFT=7).
// Expected saturated results apply when EXP_MAX_ALIGN_SAT_EN is defined.
module tb_exp_max_align;

  localparam int SAT_LIM = 7;

  typedef struct {
    logic [3:0][3:0] exps;
    logic [3:0]      max_exp;
    logic [1:0]      max_idx;
    logic [3:0][3:0] shifts;
    logic [3:0]      sat;
  } vec_t;

  typedef struct {
    logic [3:0]      max_exp;
    logic [1:0]      max_idx;
    logic [3:0][3:0] shifts;
    logic [3:0]      sat;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  vec_t            vecs[10];
  logic [3:0][3:0] stream_exp[16];
  res_t            sb_q[$];

  always #5 clk = ~clk;

  exp_max_align_if #(.EXP_WIDTH(4), .NUM_IN(4)) bus ();

  exp_max_align #(
    .EXP_WIDTH (4),
    .NUM_IN    (4),
    .SAT_SHIFT (7)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic res_t refModel(input logic [3:0][3:0] e);
    res_t r;
    int   best = 0;
    int   diff;
    for (int i = 1; i < 4; i++)
      if (e[i] > e[best]) best = i;
    r.max_exp = e[best];
    r.max_idx = 2'(best);
    r.sat     = '0;
    for (int i = 0; i < 4; i++) begin
      diff = int'(e[best]) - int'(e[i]);
`ifdef EXP_MAX_ALIGN_SAT_EN
      if (diff > SAT_LIM) begin
        diff     = SAT_LIM;
        r.sat[i] = 1'b1;
      end
`endif
      r.shifts[i] = 4'(diff);
    end
    return r;
  endfunction

  task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input res_t e);
    checkField({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkField({name, "_max"},   32'(bus.out_max_exp), 32'(e.max_exp));
    checkField({name, "_idx"},   32'(bus.out_max_idx), 32'(e.max_idx));
    checkField({name, "_shift"}, 32'(bus.out_shift), 32'(e.shifts));
    checkField({name, "_sat"},   32'(bus.out_sat), 32'(e.sat));
  endtask

  // One transaction; checks exact 3-cycle latency against the table values.
  task automatic applyStimulus(input string name, input vec_t v);
    res_t e;
    e.max_exp = v.max_exp;
    e.max_idx = v.max_idx;
    e.shifts  = v.shifts;
    e.sat     = v.sat;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_exp    = v.exps;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    @(negedge clk);
    checkField({name, "_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    checkOutput(name, e);
  endtask

  task automatic runStream(input string name, input int n, input int stall_lo, input int stall_hi,
                           input bit check_timing);
    int              sent = 0;
    int              got = 0;
    bit              hold_pending = 1'b0;
    logic [31:0]     held = '0;
    res_t            e;
    sb_q.delete();
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      bus.in_valid  = (sent < n);
      bus.in_exp    = (sent < n) ? stream_exp[sent] : '0;
      bus.out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      #1;
      if (hold_pending)
        checkField({name, "_hold"},
                   32'({bus.out_valid, bus.out_max_exp, bus.out_max_idx, bus.out_shift, bus.out_sat}), held);
      if (bus.out_valid && !bus.out_ready) begin
        checkField({name, "_in_ready_stall"}, 32'(bus.in_ready), 32'd0);
        held = 32'({bus.out_valid, bus.out_max_exp, bus.out_max_idx, bus.out_shift, bus.out_sat});
        hold_pending = 1'b1;
      end else begin
        hold_pending = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          checkField({name, "_extra_result"}, 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          checkOutput($sformatf("%s_r%0d", name, got), e);
          if (check_timing)
            checkField({name, "_cycle"}, 32'(cyc), 32'(got + 3));
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(refModel(stream_exp[sent]));
        sent++;
      end
    end
    bus.in_valid = 1'b0;
    checkField({name, "_count"}, 32'(got), 32'(n));
  endtask

  initial begin
    // Hand-computed vectors; concatenations list lane 3 first.
    vecs[0] = '{{4'd1, 4'd5, 4'd9, 4'd3},   4'd9,  2'd1, {4'd8, 4'd4, 4'd0, 4'd6},    4'b0000};
    vecs[1] = '{{4'd7, 4'd7, 4'd2, 4'd7},   4'd7,  2'd0, {4'd0, 4'd0, 4'd5, 4'd0},    4'b0000};
    vecs[2] = '{{4'd0, 4'd0, 4'd0, 4'd15},  4'd15, 2'd0, {4'd15, 4'd15, 4'd15, 4'd0}, 4'b0000};
    vecs[3] = '{{4'd6, 4'd6, 4'd6, 4'd6},   4'd6,  2'd0, {4'd0, 4'd0, 4'd0, 4'd0},    4'b0000};
    vecs[4] = '{{4'd15, 4'd0, 4'd0, 4'd0},  4'd15, 2'd3, {4'd0, 4'd15, 4'd15, 4'd15}, 4'b0000};
    vecs[5] = '{{4'd4, 4'd3, 4'd2, 4'd1},   4'd4,  2'd3, {4'd0, 4'd1, 4'd2, 4'd3},    4'b0000};
    vecs[6] = '{{4'd9, 4'd3, 4'd8, 4'd8},   4'd9,  2'd3, {4'd0, 4'd6, 4'd1, 4'd1},    4'b0000};
    vecs[7] = '{{4'd2, 4'd10, 4'd4, 4'd10}, 4'd10, 2'd0, {4'd8, 4'd0, 4'd6, 4'd0},    4'b0000};
    vecs[8] = '{{4'd0, 4'd0, 4'd0, 4'd0},   4'd0,  2'd0, {4'd0, 4'd0, 4'd0, 4'd0},    4'b0000};
    vecs[9] = '{{4'd12, 4'd12, 4'd0, 4'd1}, 4'd12, 2'd2, {4'd0, 4'd0, 4'd12, 4'd11},  4'b0000};
`ifdef EXP_MAX_ALIGN_SAT_EN
    vecs[0].shifts = {4'd7, 4'd4, 4'd0, 4'd6};  vecs[0].sat = 4'b1000;
    vecs[2].shifts = {4'd7, 4'd7, 4'd7, 4'd0};  vecs[2].sat = 4'b1110;
    vecs[4].shifts = {4'd0, 4'd7, 4'd7, 4'd7};  vecs[4].sat = 4'b0111;
    vecs[7].shifts = {4'd7, 4'd0, 4'd6, 4'd0};  vecs[7].sat = 4'b1000;
    vecs[9].shifts = {4'd0, 4'd0, 4'd7, 4'd7};  vecs[9].sat = 4'b0011;
`endif

    bus.in_valid  = 1'b0;
    bus.in_exp    = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    checkField("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkField("rst_max_exp",   32'(bus.out_max_exp), 32'd0);
    checkField("rst_max_idx",   32'(bus.out_max_idx), 32'd0);
    checkField("rst_shift",     32'(bus.out_shift), 32'd0);
    checkField("rst_sat",       32'(bus.out_sat), 32'd0);
    rst_n = 1'b1;
    #1;
    checkField("rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 10; i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i]);

    stream_exp[0] = {4'd11, 4'd4, 4'd11, 4'd2};
    stream_exp[1] = {4'd1, 4'd0, 4'd1, 4'd0};
    stream_exp[2] = {4'd12, 4'd9, 4'd3, 4'd14};
    stream_exp[3] = {4'd5, 4'd5, 4'd5, 4'd5};
    stream_exp[4] = {4'd0, 4'd1, 4'd13, 4'd7};
    runStream("stall", 5, 4, 6, 1'b0);

    // Two transactions in flight, then a one-cycle reset wipes them.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_exp    = {4'd3, 4'd14, 4'd2, 4'd8};
    @(negedge clk);
    bus.in_exp    = {4'd9, 4'd1, 4'd1, 4'd6};
    @(negedge clk);
    bus.in_valid  = 1'b0;
    rst_n         = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkField("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      checkField($sformatf("midrst_stale%0d", k), 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    applyStimulus("midrst_new", vecs[5]);

    for (int i = 0; i < 16; i++)
      stream_exp[i] = 16'($urandom_range(0, 65535));
    runStream("thru", 16, 100, 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
